// File: rtl/fire_pkg.sv
// Shared Fire-code definitions: default code parameters, mode encodings and
// the engine state type.
package fire_pkg;

  localparam int unsigned FIRE_K    = 40;
  localparam int unsigned FIRE_R    = 24;
  localparam logic [23:0] FIRE_POLY = 24'h884110;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_CHK = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } fire_state_e;

endpackage

// File: rtl/fire_lfsr_step.sv
// Combinational W-bit unroll of the Fire-code LFSR. The first message bit
// consumed is bits_i[W-1]; each bit is one single-bit shift with feedback.
module fire_lfsr_step
  import fire_pkg::*;
#(
  parameter int unsigned R          = FIRE_R,
  parameter int unsigned W          = 1,
  parameter logic [R-1:0] POLY      = FIRE_POLY
) (
  input  logic [R-1:0] state_i,
  input  logic [W-1:0] bits_i,
  output logic [R-1:0] state_o
);

  // Top stage is loaded with the feedback directly, so its tap bit is unused.
  localparam logic [R-1:0] TAPS = {1'b0, POLY[R-2:0]};

  logic [R-1:0] s;
  logic         f;

  always_comb begin
    s = state_i;
    f = 1'b0;
    for (int unsigned j = 0; j < W; j++) begin
      f = bits_i[W-1-j] ^ s[0];
      s = {f, s[R-1:1]} ^ (TAPS & {R{f}});
    end
    state_o = s;
  end

endmodule

// File: rtl/fire_lfsr_engine.sv
// Parametrised Fire-code LFSR engine with start/busy/done handshake; encodes
// a K-bit message into R parity bits or checks it against received parity.
module fire_lfsr_engine
  import fire_pkg::*;
#(
  parameter int unsigned K     = FIRE_K,
  parameter int unsigned R     = FIRE_R,
  parameter int unsigned W     = 1,
  parameter logic [R-1:0] POLY = FIRE_POLY
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         mode,
  input  logic [K-1:0]                 data_in,
  input  logic [R-1:0]                 parity_in,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(K/W+1)-1:0]     count,
  output logic [R-1:0]                 parity_out,
  output logic [R-1:0]                 syndrome,
  output logic                         error
);

  localparam int unsigned BEATS = K / W;
  localparam int unsigned CW    = $clog2(K/W+1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  if ((W == 0) || (W > K) || ((K % W) != 0) || (POLY[R-1] != 1'b1)) begin : g_bad_params
    $error("fire_lfsr_engine: need 1 <= W <= K, K %% W == 0 and POLY[R-1] set");
  end

  fire_state_e    state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic [K-1:0]   data_q, data_d;
  logic [R-1:0]   par_in_q, par_in_d;
  logic           mode_q, mode_d;
  logic [R-1:0]   lfsr_q, lfsr_d;
  logic [R-1:0]   parity_q, parity_d;
  logic [R-1:0]   synd_q, synd_d;
  logic           err_q, err_d;
  logic [R-1:0]   lfsr_nxt;
  logic [R-1:0]   diff;

  // Latched message is shifted left each beat, so the next W bits are always
  // at the top; equivalent to indexing data[K-1-(count*W+j)].
  fire_lfsr_step #(
    .R    (R),
    .W    (W),
    .POLY (POLY)
  ) u_step (
    .state_i (lfsr_q),
    .bits_i  (data_q[K-1 -: W]),
    .state_o (lfsr_nxt)
  );

  assign diff = lfsr_nxt ^ par_in_q;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    data_d   = data_q;
    par_in_d = par_in_q;
    mode_d   = mode_q;
    lfsr_d   = lfsr_q;
    parity_d = parity_q;
    synd_d   = synd_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          data_d   = data_in;
          par_in_d = parity_in;
          mode_d   = mode;
          lfsr_d   = '0;
          count_d  = '0;
          state_d  = SHIFT;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        lfsr_d  = lfsr_nxt;
        data_d  = data_q << W;
        count_d = count_q + 1'b1;
        if (count_q == LAST_BEAT) begin
          state_d  = DONE;
          parity_d = lfsr_nxt;
          synd_d   = (mode_q == MODE_CHK) ? diff : '0;
          err_d    = (mode_q == MODE_CHK) && (|diff);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      data_q   <= '0;
      par_in_q <= '0;
      mode_q   <= MODE_ENC;
      lfsr_q   <= '0;
      parity_q <= '0;
      synd_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      data_q   <= data_d;
      par_in_q <= par_in_d;
      mode_q   <= mode_d;
      lfsr_q   <= lfsr_d;
      parity_q <= parity_d;
      synd_q   <= synd_d;
      err_q    <= err_d;
    end
  end

  assign busy       = (state_q == SHIFT);
  assign done       = (state_q == DONE);
  assign count      = count_q;
  assign parity_out = parity_q;
  assign syndrome   = synd_q;
  assign error      = err_q;

endmodule
